// File: rtl/digit_accumulator.sv
// Digit accumulator: turns a stream of decoded BCD digit strobes into a binary
// operand, with enter/clear control and overflow / bad-digit reporting.
module digit_accumulator #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OPW        = 14
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic [3:0]     num,
  input  logic           num_valid,
  input  logic           enter,
  input  logic           clear,
  output logic [OPW-1:0] acc,
  output logic [2:0]     digit_count,
  output logic [OPW-1:0] operand,
  output logic           operand_valid,
  output logic           overflow,
  output logic           bad_digit
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] acc_q, acc_d;
  logic [CW-1:0]  digit_count_q, digit_count_d;
  logic [OPW-1:0] operand_q, operand_d;
  logic           operand_valid_q, operand_valid_d;
  logic           overflow_q, overflow_d;
  logic           bad_digit_q, bad_digit_d;

  logic [CW-1:0]  count_inc;
  logic [OPW-1:0] acc_times10_plus;

  // Shift-and-add multiply by ten; cannot wrap while the entry is below MAX_DIGITS.
  always_comb begin
    count_inc        = digit_count_q + CW'(1);
    acc_times10_plus = (acc_q << 3) + (acc_q << 1) + OPW'(num);
  end

  // Next-state and output decode; clear beats enter beats num_valid.
  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    digit_count_d   = digit_count_q;
    operand_d       = operand_q;
    operand_valid_d = 1'b0;
    overflow_d      = 1'b0;
    bad_digit_d     = 1'b0;

    if (clear) begin
      state_d       = EMPTY;
      acc_d         = '0;
      digit_count_d = '0;
      operand_d     = '0;
    end else if (enter) begin
      if ((state_q == ENTRY) || (state_q == FULL)) begin
        operand_d       = acc_q;
        operand_valid_d = 1'b1;
        state_d         = DONE;
      end
    end else if (num_valid) begin
      if (num > 4'd9) begin
        bad_digit_d = 1'b1;
      end else begin
        case (state_q)
          EMPTY, DONE: begin
            acc_d         = OPW'(num);
            digit_count_d = CW'(1);
            state_d       = (MAX_DIGITS == 1) ? FULL : ENTRY;
          end
          ENTRY: begin
            acc_d         = acc_times10_plus;
            digit_count_d = count_inc;
            if (count_inc == CW'(MAX_DIGITS)) begin
              state_d = FULL;
            end
          end
          FULL: begin
            overflow_d = 1'b1;
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= EMPTY;
      acc_q           <= '0;
      digit_count_q   <= '0;
      operand_q       <= '0;
      operand_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      bad_digit_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      digit_count_q   <= digit_count_d;
      operand_q       <= operand_d;
      operand_valid_q <= operand_valid_d;
      overflow_q      <= overflow_d;
      bad_digit_q     <= bad_digit_d;
    end
  end

  assign acc           = acc_q;
  assign digit_count   = digit_count_q;
  assign operand       = operand_q;
  assign operand_valid = operand_valid_q;
  assign overflow      = overflow_q;
  assign bad_digit     = bad_digit_q;

endmodule
